// File: rtl/mealy_pattern_detector.sv
// ============================================================================
//  Module      : mealy_pattern_detector
//  Description : Mealy detector matching a sliding WIDTH-bit window of a
//                qualified serial stream against two programmable patterns,
//                with overlapping/non-overlapping modes. Optional saturating
//                match counters are built when MEALY_MATCH_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_pattern_detector #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             i,
    input  logic             overlap,
    input  logic [WIDTH-1:0] pat_a,
    input  logic [WIDTH-1:0] pat_b,
    output logic [1:0]       o,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int                FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] c_FULL   = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] c_ONE    = FILL_W'(1);

    logic [WIDTH-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;

    logic [WIDTH-2:0]  w_hist_shift;
    logic [WIDTH-2:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [WIDTH-1:0]  w_window;
    logic              w_accept;
    logic              w_arm;
    logic              w_match_a;
    logic              w_match_b;

    // Newest bit enters at bit 0; the oldest history bit falls off the top.
    generate
        if (WIDTH == 2) begin : g_hist_w2
            assign w_hist_shift = i;
        end else begin : g_hist_wn
            assign w_hist_shift = {r_hist[WIDTH-3:0], i};
        end
    endgenerate

    assign w_window  = {r_hist, i};
    assign w_accept  = in_valid & ~clear;
    assign w_arm     = w_accept & (r_fill == c_FULL);
    assign w_match_a = w_arm & (w_window == pat_a);
    assign w_match_b = w_arm & (w_window == pat_b);
    assign o         = {w_match_a, w_match_b};

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (clear) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (in_valid) begin
            w_hist_nxt = w_hist_shift;
            if (!overlap && (w_match_a || w_match_b)) begin
                // Non-overlapping: the next match needs a fully fresh window.
                w_fill_nxt = '0;
            end else if (r_fill != c_FULL) begin
                w_fill_nxt = r_fill + c_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

`ifdef MEALY_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;

    // o is forced low during clear, so clear alone governs the counters then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else if (clear) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (w_match_a && (r_count_a != {CNT_W{1'b1}})) begin
                r_count_a <= r_count_a + CNT_W'(1);
            end
            if (w_match_b && (r_count_b != {CNT_W{1'b1}})) begin
                r_count_b <= r_count_b + CNT_W'(1);
            end
        end
    end

    assign count_a = r_count_a;
    assign count_b = r_count_b;
`else
    assign count_a = '0;
    assign count_b = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_pattern_detector.sv
// Directed self-checking bench for mealy_pattern_detector (WIDTH=3, A=001, B=111);
// a second instance with CNT_W=2 exercises counter saturation on the same stimulus.
`default_nettype none

module tb_mealy_pattern_detector;

`ifdef MEALY_MATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       i = 1'b0;
    logic       overlap = 1'b1;
    logic [2:0] pat_a = 3'b001;
    logic [2:0] pat_b = 3'b111;
    logic [1:0] o;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic [1:0] o2;
    logic [1:0] count_a2;
    logic [1:0] count_b2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mealy_pattern_detector #(.WIDTH(3), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .i(i), .overlap(overlap), .pat_a(pat_a), .pat_b(pat_b),
        .o(o), .count_a(count_a), .count_b(count_b)
    );

    mealy_pattern_detector #(.WIDTH(3), .CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .i(i), .overlap(overlap), .pat_a(pat_a), .pat_b(pat_b),
        .o(o2), .count_a(count_a2), .count_b(count_b2)
    );

    function automatic logic [7:0] ecnt(input int n);
        return CNT_EN ? 8'(n) : 8'd0;
    endfunction

    // Present one beat mid-cycle; o is then observable before the next rising edge.
    task automatic drive(input logic v, input logic b);
        @(negedge clock);
        in_valid = v;
        i        = b;
        #1;
    endtask

    task automatic clear_cycle();
        @(negedge clock);
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (o !== 2'b00 || count_a !== 8'd0 || count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: o=%b ca=%0d cb=%0d, want o=00 ca=0 cb=0", o, count_a, count_b);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_overlap_stream();
        logic [9:0] bits = 10'b1110011001;
        logic [9:0] ea   = 10'b0000010001;
        logic [9:0] eb   = 10'b0010000000;
        overlap = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, bits[9-k]);
            n_tests++;
            if (o !== {ea[9-k], eb[9-k]}) begin
                n_fail++;
                $display("FAIL overlap_stream beat %0d: o=%b, want %b", k + 1, o, {ea[9-k], eb[9-k]});
            end
        end
        drive(1'b0, 1'b0);
        n_tests++;
        if (count_a !== ecnt(2) || count_b !== ecnt(1)) begin
            n_fail++;
            $display("FAIL overlap_stream counts: ca=%0d cb=%0d, want ca=%0d cb=%0d",
                     count_a, count_b, ecnt(2), ecnt(1));
        end
    endtask

    task automatic test_six_ones();
        logic [5:0] eb_ov  = 6'b001111;
        logic [5:0] eb_nov = 6'b001001;
        for (int m = 0; m < 2; m++) begin
            clear_cycle();
            overlap = (m == 0);
            for (int k = 0; k < 6; k++) begin
                drive(1'b1, 1'b1);
                n_tests++;
                if (o !== {1'b0, (m == 0) ? eb_ov[5-k] : eb_nov[5-k]}) begin
                    n_fail++;
                    $display("FAIL six_ones ov=%0d beat %0d: o=%b, want %b", overlap, k + 1, o,
                             {1'b0, (m == 0) ? eb_ov[5-k] : eb_nov[5-k]});
                end
            end
            drive(1'b0, 1'b0);
            n_tests++;
            if (count_b !== ecnt((m == 0) ? 4 : 2) || count_a !== 8'd0) begin
                n_fail++;
                $display("FAIL six_ones ov=%0d counts: ca=%0d cb=%0d, want ca=0 cb=%0d",
                         overlap, count_a, count_b, ecnt((m == 0) ? 4 : 2));
            end
        end
        overlap = 1'b1;
    endtask

    task automatic test_saturation();
        logic [1:0] exp;
        clear_cycle();
        overlap = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1);
            @(posedge clock);
            #1;
            exp = (k < 3) ? 2'd0 : ((k - 2) >= 3 ? 2'd3 : 2'(k - 2));
            if (!CNT_EN) exp = 2'd0;
            n_tests++;
            if (count_b2 !== exp) begin
                n_fail++;
                $display("FAIL saturation after beat %0d: cb=%0d, want %0d", k, count_b2, exp);
            end
        end
    endtask

    task automatic test_invalid_gap();
        clear_cycle();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1);
            n_tests++;
            if (o !== 2'b00) begin
                n_fail++;
                $display("FAIL invalid_gap idle %0d: o=%b, want 00", k, o);
            end
        end
        drive(1'b1, 1'b1);
        n_tests++;
        if (o !== 2'b10) begin
            n_fail++;
            $display("FAIL invalid_gap match: o=%b, want 10", o);
        end
        drive(1'b0, 1'b0);
        n_tests++;
        if (count_a !== ecnt(1) || count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL invalid_gap counts: ca=%0d cb=%0d, want ca=%0d cb=0", count_a, count_b, ecnt(1));
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] eb = 3'b001;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clock);
        in_valid = 1'b1;
        i        = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (o !== 2'b00 || count_a !== 8'd0 || count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: o=%b ca=%0d cb=%0d, want o=00 ca=0 cb=0", o, count_a, count_b);
        end
        in_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1);
            n_tests++;
            if (o !== {1'b0, eb[2-k]}) begin
                n_fail++;
                $display("FAIL async_reset post beat %0d: o=%b, want %b", k + 1, o, {1'b0, eb[2-k]});
            end
        end
    endtask

    task automatic test_clear();
        logic [2:0] bits = 3'b001;
        logic [2:0] ea   = 3'b001;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        @(negedge clock);
        in_valid = 1'b1;
        i        = 1'b1;
        clear    = 1'b1;
        #1;
        n_tests++;
        if (o !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_cycle o: o=%b, want 00", o);
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
        n_tests++;
        if (count_a !== 8'd0 || count_b !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_counts: ca=%0d cb=%0d, want 0 0", count_a, count_b);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, bits[2-k]);
            n_tests++;
            if (o !== {ea[2-k], 1'b0}) begin
                n_fail++;
                $display("FAIL clear_post beat %0d: o=%b, want %b", k + 1, o, {ea[2-k], 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_stream();
        test_six_ones();
        test_saturation();
        test_invalid_gap();
        test_async_reset();
        test_clear();
        drive(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
